rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001: Parameter STARVE_LIMIT, default 3: consecutive cycles a buffered mem write may lose arbitration before it is forced through.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: alu_valid  input  1  ALU writeback request present.
REQ-005: alu_addr  input  5  ALU destination register.
REQ-006: alu_data  input  36  ALU write value.
REQ-007: alu_ready  output  1  ALU request granted this cycle (combinational).
REQ-008: mem_valid  input  1  load writeback request present.
REQ-009: mem_addr  input  5  load destination register.
REQ-010: mem_data  input  36  load write value.
REQ-011: mem_ready  output  1  mem FIFO can accept (registered-derived, = not full).
REQ-012: rf_we  output  1  register-file write enable (registered).
REQ-013: rf_waddr  output  5  register-file write address (registered).
REQ-014: rf_wdata  output  36  register-file write data (registered).
REQ-015: mem_count  output  2  current mem FIFO occupancy, 0..2.

Function
REQ-016: Block SHALL share the single register-file write port between the ALU and load writeback paths.
REQ-017: Mem path SHALL buffer in a 2-entry in-order FIFO; push on mem_valid & mem_ready; ALU path is unbuffered.
REQ-018: mem_ready SHALL be 0 when mem_count==2, even if a pop occurs that cycle.
REQ-019: Each cycle grant SHALL be: MEM if FIFO non-empty and starve_cnt >= STARVE_LIMIT; else ALU if alu_valid; else MEM if FIFO non-empty; else none.
REQ-020: alu_ready SHALL be 1 exactly when ALU is granted; alu_valid with alu_ready=0 SHALL be held stable by the sender.
REQ-021: A grant in cycle N SHALL produce rf_we=1 with granted addr/data in cycle N+1; no grant gives rf_we=0 in N+1, with rf_waddr/rf_wdata holding their previous values.
REQ-022: MEM grant SHALL pop the FIFO head in the same cycle; simultaneous push and pop SHALL leave mem_count unchanged.
REQ-023: A mem request pushed into an empty FIFO SHALL be grantable no earlier than the following cycle (no bypass).
REQ-024: starve_cnt (2 bits, saturating at 3) SHALL increment when FIFO non-empty and MEM not granted, and clear to 0 when MEM granted or FIFO empty.
REQ-025: Mem writes SHALL retire in arrival order; no ordering is enforced between the ALU and mem paths.
REQ-026: At most one write per cycle SHALL reach the register file.

Reset
REQ-027: rst_n low SHALL immediately clear rf_we, rf_waddr, rf_wdata, mem_count, starve_cnt, and FIFO pointers to 0; mem_ready SHALL read 1.
REQ-028: Reset mid-operation SHALL discard buffered mem writes; no rf_we pulse SHALL follow reset release until a new grant.

Configuration
REQ-029: Macro WB_R0_DROP_EN: when defined, a granted write to address 0 from either path SHALL complete its handshake/pop but drive rf_we=0 in N+1.
REQ-030: Without WB_R0_DROP_EN, writes to address 0 SHALL be issued like any other address.

Verification
REQ-031: ALU-only: alu_valid=1, addr=5, data=36'h123456789 in cycle 0 -> alu_ready=1 in cycle 0; rf_we=1, rf_waddr=5, rf_wdata=36'h123456789 in cycle 1.
REQ-032: Mem fill: three back-to-back mem_valid with alu_valid held 1 -> first two accepted, mem_ready=0 on third, mem_count=2.
REQ-033: Starvation: FIFO holds one entry, alu_valid held 1 continuously, STARVE_LIMIT=3 -> ALU granted 3 cycles, MEM granted in 4th cycle, alu_ready=0 that cycle.
REQ-034: Simultaneous push/pop: mem_count=1, alu_valid=0, new mem_valid -> head written, mem_count stays 1, order preserved (addr 7 then addr 9).
REQ-035: Async reset with mem_count=2 asserted mid-cycle -> outputs zero immediately, mem_ready=1, no rf_we after release.
REQ-036: WB_R0_DROP_EN defined, ALU write to addr 0 -> alu_ready=1, rf_we stays 0; undefined -> rf_we=1, rf_waddr=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//   Shares the single register-file write port between the unbuffered ALU
//   writeback path and the load (mem) writeback path. Load writes are held
//   in a 2-entry in-order FIFO. The ALU has priority, but a buffered load
//   that has lost arbitration STARVE_LIMIT cycles in a row is forced through.
//
// Handshake: a request transfers in a cycle where valid && ready are both
//   high at the rising edge. The sender holds valid and its payload stable
//   until ready is seen. alu_ready is combinational and means "granted now".
//   mem_ready is derived only from registered occupancy, so it never depends
//   on this cycle's grant.
//
// Parameters
//   STARVE_LIMIT  consecutive lost arbitrations before a buffered load wins
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   alu_valid/addr/data/ready   ALU writeback request (unbuffered)
//   mem_valid/addr/data/ready   load writeback request (into the FIFO)
//   rf_we/rf_waddr/rf_wdata     registered register-file write port
//   mem_count                   current FIFO occupancy (0..2)
//
// Build option
//   WB_R0_DROP_EN  when defined, a granted write to r0 completes its
//                  handshake/pop but does not assert rf_we.
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [35:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_addr,
  input  logic [35:0] mem_data,
  output logic        mem_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [35:0] rf_wdata,
  output logic [1:0]  mem_count
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } grant_e;

  // FIFO entry is {addr, data}
  logic [40:0] fifo_q [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count_q;
  logic [1:0]  starve_q;

  logic        fifo_empty;
  logic        starve_hit;
  logic        push;
  logic        pop;
  grant_e      grant;
  logic [40:0] head;
  logic [4:0]  sel_addr;
  logic [35:0] sel_data;
  logic        issue;

  assign fifo_empty = (count_q == 2'd0);
  assign starve_hit = (int'(starve_q) >= STARVE_LIMIT);
  assign head       = fifo_q[rd_ptr];

  // Full blocks acceptance even when a pop happens this cycle; keeps
  // mem_ready off the grant path.
  assign mem_ready  = (count_q != 2'd2);
  assign push       = mem_valid & mem_ready;
  assign mem_count  = count_q;

  // Arbitration looks only at registered FIFO state, so a load pushed this
  // cycle cannot be granted until the next one.
  always_comb begin
    grant = GNT_NONE;
    if (!fifo_empty && starve_hit) begin
      grant = GNT_MEM;
    end else if (alu_valid) begin
      grant = GNT_ALU;
    end else if (!fifo_empty) begin
      grant = GNT_MEM;
    end
  end

  assign alu_ready = (grant == GNT_ALU);
  assign pop       = (grant == GNT_MEM);

  always_comb begin
    sel_addr = alu_addr;
    sel_data = alu_data;
    if (grant == GNT_MEM) begin
      sel_addr = head[40:36];
      sel_data = head[35:0];
    end
  end

`ifdef WB_R0_DROP_EN
  assign issue = (grant != GNT_NONE) && (sel_addr != 5'd0);
`else
  assign issue = (grant != GNT_NONE);
`endif

  // FIFO payload storage; contents are don't-care while the entry is unused.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= {mem_addr, mem_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count_q  <= 2'd0;
      starve_q <= 2'd0;
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 36'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;

      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase

      // Counts consecutive losses of a waiting load; saturates at 3.
      if (fifo_empty || pop) begin
        starve_q <= 2'd0;
      end else if (starve_q != 2'd3) begin
        starve_q <= starve_q + 2'd1;
      end

      // Address/data only change on an issued write; otherwise they hold.
      rf_we <= issue;
      if (issue) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

endmodule
